life_scan_ctrl: RTL

- Sequencer between the system controller and the life_cell array.
- Issues one-cycle generation-step strobes to the array's enb inputs.
- After each step, and on snapshot request, drives the array's scan input to rotate every row west by one column per cycle. Each west-edge column is presented on a valid/ready stream for the display/readout stage.
- After COLS shifts the array is back in its original orientation.

---
 rtl/life_scan_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/life_scan_ctrl.sv
`timescale 1ns/1ps
// life_scan_ctrl: sequencer between the system controller and the life_cell
// array. It issues one-cycle generation strobes (cell_enb) and then rotates
// every row west one column per accepted transfer (scan), presenting each
// west-edge column on a valid/ready stream. After COLS transfers the array is
// back in its original orientation.
//
// Stream handshake: a column transfers on a rising clk edge where out_valid
// and out_ready are both high. out_valid, once raised in SCAN, stays high and
// out_data stays stable until that transfer happens. scan is the handshake
// itself, so the array shifts on exactly the transfer edge and the next
// column appears in the following cycle.
//
// A reset taken mid-SCAN leaves the array partially rotated. The controller
// does not track or undo this; the next frame starts from whatever
// orientation the array holds.
module life_scan_ctrl #(
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int GEN_PERIOD = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            snap,
  input  logic [ROWS-1:0] col_data,
  output logic            cell_enb,
  output logic            scan,
  output logic [ROWS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            frame_start,
  output logic            frame_done,
  output logic [15:0]     gen_count,
  output logic            busy,
  output logic [2:0]      state_dbg
);

  localparam int TW = (GEN_PERIOD > 2) ? $clog2(GEN_PERIOD) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(GEN_PERIOD - 1);
  localparam logic [CW-1:0] COL_LAST     = CW'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVOLVE = 3'd1,
    SETTLE = 3'd2,
    SCAN   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            pending;
  logic [CW-1:0]   col_cnt;
  logic [15:0]     gen_q;
  logic            timer_expire;
  logic            handshake;
  logic            start_gen;

  // out_valid is only ever high in SCAN, so the handshake can only occur there.
  assign handshake    = out_valid && out_ready;
  assign timer_expire = run && (timer == '0);
  // A generation request is taken only in IDLE; step/snap elsewhere are dropped.
  assign start_gen    = (state == IDLE) && (pending || step);

  assign scan      = handshake;
  assign out_data  = col_data;
  assign gen_count = gen_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Free-running generation timer: counts down while run is high, holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= TIMER_RELOAD;
    end else if (run) begin
      if (timer == '0) begin
        timer <= TIMER_RELOAD;
      end else begin
        timer <= timer - 1'b1;
      end
    end
  end

  // Sequencer FSM with registered strobes, counters and the pending-request flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cell_enb    <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      gen_q       <= 16'd0;
      pending     <= 1'b0;
      col_cnt     <= '0;
    end else begin
      // Taking the request consumes any pending expiry.
      if (start_gen) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending || step) begin
            // step+snap together: the frame after the generation covers snap.
            cell_enb <= 1'b1;
            state    <= EVOLVE;
          end else if (snap) begin
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
            col_cnt     <= '0;
            state       <= SCAN;
          end
        end

        EVOLVE: begin
          cell_enb <= 1'b0;
          gen_q    <= gen_q + 16'd1;
          state    <= SETTLE;
        end

        SETTLE: begin
          // Cells took their new state on the edge that ended EVOLVE.
          out_valid   <= 1'b1;
          frame_start <= 1'b1;
          col_cnt     <= '0;
          state       <= SCAN;
        end

        SCAN: begin
          if (handshake) begin
            frame_start <= 1'b0;
            if (col_cnt == COL_LAST) begin
              col_cnt    <= '0;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          cell_enb    <= 1'b0;
          out_valid   <= 1'b0;
          frame_start <= 1'b0;
          frame_done  <= 1'b0;
          col_cnt     <= '0;
          state       <= IDLE;
        end
      endcase

      // An expiry in the same cycle as consumption must not be lost; further
      // expiries while a request is already pending collapse into it.
      if (timer_expire) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
